// File: rtl/dffram_fifo_ctrl.sv
// dffram_fifo_ctrl: first-word-fall-through FIFO built on the single port of
// a 128x32 DFFRAM macro. The controller gives one RAM access to each cycle.
// Reads that refill the output register take priority over writes. A
// one-word output register keeps the head word visible to the consumer.
// Total capacity is DEPTH+1 words: the RAM contents plus the output register.
//
// Optional feature: define DFFRAM_FIFO_BYPASS_EN to let a push into an empty
// FIFO go straight into the output register without touching the RAM.
// Without the macro, every word passes through the RAM, and a push reaches
// rd_valid three cycles later.
module dffram_fifo_ctrl #(
  parameter int AW     = 7,
  parameter int DATA_W = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic [AW:0]           count,
  output logic                  full,
  output logic [DATA_W/8-1:0]   ram_we,
  output logic                  ram_en,
  output logic [AW-1:0]         ram_a,
  output logic [DATA_W-1:0]     ram_di,
  input  logic [DATA_W-1:0]     ram_do
);

  // ram_cnt == DEPTH means that every RAM word is occupied
  localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       ram_cnt;
  logic              rd_pend;
  logic              out_valid;
  logic [DATA_W-1:0] out_reg;

  logic              pop;
  logic              push;
  logic              rd_issue;
  logic              bypass;
  logic              ram_wr;
  logic              ram_full;

  assign ram_full = (ram_cnt == DEPTH_CNT);

  // A pop frees the output register, so a refill read can be issued in the
  // same cycle. This makes the path rd_ready -> rd_issue -> wr_ready combinational.
  assign pop      = out_valid & rd_ready & ~RST;
  assign rd_issue = ~RST & (ram_cnt != '0) & ~rd_pend & (~out_valid | pop);
  assign wr_ready = ~RST & ~ram_full & ~rd_issue;
  assign push     = wr_valid & wr_ready;

`ifdef DFFRAM_FIFO_BYPASS_EN
  // An empty FIFO with a free output register takes the word directly
  assign bypass = push & (ram_cnt == '0) & ~rd_pend & (~out_valid | pop);
`else
  assign bypass = 1'b0;
`endif

  assign ram_wr = push & ~bypass;

  // Outputs are forced to zero while reset is held, before the registers clear
  assign rd_valid = out_valid & ~RST;
  assign rd_data  = RST ? '0 : out_reg;
  assign full     = ~RST & ram_full;
  assign count    = RST ? '0
                  : ram_cnt + {{AW{1'b0}}, rd_pend} + {{AW{1'b0}}, out_valid};

  // RAM port arbitration: a read issue wins, and an unused port is held at zero
  always_comb begin
    ram_en = 1'b0;
    ram_we = '0;
    ram_a  = '0;
    ram_di = '0;
    if (rd_issue) begin
      ram_en = 1'b1;
      ram_a  = rptr;
    end else if (ram_wr) begin
      ram_en = 1'b1;
      ram_we = '1;
      ram_a  = wptr;
      ram_di = wr_data;
    end
  end

  // Pointers, occupancy and read-in-flight flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (ram_wr) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_issue) begin
        rptr <= rptr + 1'b1;
      end
      // A read issue and a RAM write never share a cycle
      if (ram_wr) begin
        ram_cnt <= ram_cnt + 1'b1;
      end else if (rd_issue) begin
        ram_cnt <= ram_cnt - 1'b1;
      end
      rd_pend <= rd_issue;
    end
  end

  // Output register: fill from the RAM read, bypass load, or drain on pop.
  // Clearing rd_pend on reset discards any RAM read that is still in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_reg   <= '0;
    end else if (rd_pend) begin
      out_reg   <= ram_do;
      out_valid <= 1'b1;
    end else if (bypass) begin
      out_reg   <= wr_data;
      out_valid <= 1'b1;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

endmodule
